// File: rtl/bcd_serial_adder_pkg.sv
// Shared types and constants for the serial packed-BCD adder.
// BCD_DIGIT_CHECK_EN enables invalid-digit detection (err output).
package bcd_serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX     = 4'd9;
  localparam logic [3:0] BCD_ADJ     = 4'd6;
  localparam int         BCD_DIGIT_W = 4;

  function automatic logic bad_digit(
    input logic [3:0] d
  );
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_serial_adder_if.sv
// Operand/result handshake bundle for the serial BCD adder.
// master drives operands and out_ready; slave is the adder.
interface bcd_serial_adder_if #(
  parameter int DIGITS = 4
);

  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  busy;
  logic                  err;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout,
    input  busy, err
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout,
    output busy, err
  );

endinterface

// File: rtl/bcd_digit_add.sv
// Single-digit decimal adder with +6 correction.
// invalid reports a non-BCD input only under BCD_DIGIT_CHECK_EN.
module bcd_digit_add
  import bcd_serial_adder_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       invalid
);

  logic [4:0] t;

  assign t = {1'b0, a} + {1'b0, b}
           + {4'b0, cin};

  // t > 9 as gates: any of 16..31, or 10..15
  assign cout = t[4] | (t[3] & (t[2] | t[1]));

  assign s = cout ? t[3:0] + BCD_ADJ
                  : t[3:0];

`ifdef BCD_DIGIT_CHECK_EN
  assign invalid = bad_digit(a) | bad_digit(b);
`else
  assign invalid = 1'b0;
`endif

endmodule

// File: rtl/bcd_serial_adder.sv
// Serial packed-BCD adder: one digit per clock, LSD first.
// BCD_DIGIT_CHECK_EN enables the sticky invalid-digit err flag.
module bcd_serial_adder
  import bcd_serial_adder_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int CW     = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  bcd_serial_adder_if.slave io
);

  localparam int W = BCD_DIGIT_W * DIGITS;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    sum_q;
  logic            carry_q;
  logic            cout_q;
  logic            err_q;

  logic [3:0]      dig_s;
  logic            dig_co;
  logic            dig_inv;
  logic            last;
  logic            accept;

  assign last   = cnt_q == CW'(DIGITS - 1);
  assign accept = (state_q == ST_IDLE)
                & io.in_valid;

  bcd_digit_add u_dig (
    .a       (a_q[3:0]),
    .b       (b_q[3:0]),
    .cin     (carry_q),
    .s       (dig_s),
    .cout    (dig_co),
    .invalid (dig_inv)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (io.in_valid)  state_d = ST_RUN;
      ST_RUN:  if (last)         state_d = ST_DONE;
      ST_DONE: if (io.out_ready) state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // operands shift right so the active digit is always [3:0]
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      cnt_q   <= '0;
      a_q     <= io.a;
      b_q     <= io.b;
      sum_q   <= '0;
      carry_q <= io.cin;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (state_q == ST_RUN) begin
      cnt_q   <= cnt_q + CW'(1);
      a_q     <= a_q >> BCD_DIGIT_W;
      b_q     <= b_q >> BCD_DIGIT_W;
      sum_q   <= (sum_q >> BCD_DIGIT_W)
               | (W'(dig_s) << (W - BCD_DIGIT_W));
      carry_q <= dig_co;
      err_q   <= err_q | dig_inv;
      if (last) begin
        cout_q <= dig_co;
      end
    end
  end

  assign io.in_ready  = state_q == ST_IDLE;
  assign io.busy      = state_q != ST_IDLE;
  assign io.out_valid = state_q == ST_DONE;
  assign io.sum       = sum_q;
  assign io.cout      = cout_q;
  assign io.err       = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Randomized bench for bcd_serial_adder against a decimal model.
// Build with BCD_DIGIT_CHECK_EN to expect the err flag.
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

`ifdef BCD_DIGIT_CHECK_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  exp_t expq[$];

  bcd_serial_adder_if #(.DIGITS(DIGITS)) io ();

  bcd_serial_adder #(
    .DIGITS (DIGITS),
    .CW     (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] req
  );
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h",
               nm, act, req);
    end
  endtask

  function automatic longint from_bcd(
    input logic [W-1:0] x
  );
    longint v = 0;
    for (int k = DIGITS - 1; k >= 0; k--)
      v = v * 10 + longint'(x[4*k +: 4]);
    return v;
  endfunction

  function automatic logic [W-1:0] to_bcd(
    input longint v
  );
    logic [W-1:0] r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // valid-BCD operands only: plain decimal addition
  function automatic exp_t model(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         c
  );
    exp_t   e;
    longint lim = 1;
    longint tot;
    for (int k = 0; k < DIGITS; k++) lim *= 10;
    tot    = from_bcd(a) + from_bcd(b) + longint'(c);
    e.sum  = to_bcd(tot % lim);
    e.cout = tot >= lim;
    e.err  = 1'b0;
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_bcd();
    logic [W-1:0] r;
    for (int k = 0; k < DIGITS; k++)
      r[4*k +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && io.out_valid) begin
      if (expq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious out_valid: got 1, want 0");
      end else begin
        chk("sum",  64'(io.sum),  64'(expq[0].sum));
        chk("cout", 64'(io.cout), 64'(expq[0].cout));
        chk("err",  64'(io.err),  64'(expq[0].err));
        chk("busy in done", 64'(io.busy), 64'd1);
        if (io.out_ready) void'(expq.pop_front());
      end
    end
  end

  task automatic run_op(
    input logic [W-1:0] av,
    input logic [W-1:0] bv,
    input logic         c,
    input int           hold,
    input exp_t         e
  );
    io.a        = av;
    io.b        = bv;
    io.cin      = c;
    io.in_valid = 1'b1;
    chk("in_ready idle", 64'(io.in_ready), 64'd1);
    expq.push_back(e);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    io.a        = W'($urandom);
    io.b        = W'($urandom);
    chk("in_ready run", 64'(io.in_ready), 64'd0);
    chk("busy run", 64'(io.busy), 64'd1);
    chk("early valid", 64'(io.out_valid), 64'd0);
    repeat (DIGITS - 1) begin
      @(posedge clk);
      #1;
      chk("early valid", 64'(io.out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    chk("latency", 64'(io.out_valid), 64'd1);
    repeat (hold) begin
      io.in_valid = 1'b1;
      io.a        = W'($urandom);
      io.b        = W'($urandom);
      @(posedge clk);
      #1;
      chk("stall valid", 64'(io.out_valid), 64'd1);
      chk("stall in_ready", 64'(io.in_ready), 64'd0);
    end
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    @(posedge clk);
    #1;
    io.out_ready = 1'b0;
    chk("valid drop", 64'(io.out_valid), 64'd0);
    chk("in_ready back", 64'(io.in_ready), 64'd1);
    chk("busy idle", 64'(io.busy), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t         e;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic         c;
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    io.in_valid  = 1'b0;
    io.out_ready = 1'b0;
    io.a         = '0;
    io.b         = '0;
    io.cin       = 1'b0;
    #2;
    chk("rst in_ready", 64'(io.in_ready), 64'd1);
    chk("rst out_valid", 64'(io.out_valid), 64'd0);
    chk("rst busy", 64'(io.busy), 64'd0);
    chk("rst sum", 64'(io.sum), 64'd0);
    chk("rst cout", 64'(io.cout), 64'd0);
    chk("rst err", 64'(io.err), 64'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    e = model(16'h1234, 16'h5678, 1'b0);
    chk("model 1234+5678", 64'({e.sum, e.cout}),
        64'({16'h6912, 1'b0}));
    run_op(16'h1234, 16'h5678, 1'b0, 0, e);

    e = model(16'h9999, 16'h0001, 1'b0);
    chk("model 9999+0001", 64'({e.sum, e.cout}),
        64'({16'h0000, 1'b1}));
    run_op(16'h9999, 16'h0001, 1'b0, 2, e);

    e = model(16'h0000, 16'h0000, 1'b1);
    chk("model 0+0+1", 64'({e.sum, e.cout}),
        64'({16'h0001, 1'b0}));
    run_op(16'h0000, 16'h0000, 1'b1, 0, e);

    e = model(16'h4999, 16'h5000, 1'b1);
    chk("model 4999+5000+1", 64'({e.sum, e.cout}),
        64'({16'h0000, 1'b1}));
    run_op(16'h4999, 16'h5000, 1'b1, 5, e);

    io.a        = 16'h1234;
    io.b        = 16'h5678;
    io.cin      = 1'b0;
    io.in_valid = 1'b1;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort sum", 64'(io.sum), 64'd0);
    chk("abort cout", 64'(io.cout), 64'd0);
    chk("abort busy", 64'(io.busy), 64'd0);
    chk("abort in_ready", 64'(io.in_ready), 64'd1);
    chk("abort out_valid", 64'(io.out_valid), 64'd0);
    expq.delete();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    e = model(16'h0005, 16'h0005, 1'b0);
    chk("model 5+5", 64'({e.sum, e.cout}),
        64'({16'h0010, 1'b0}));
    run_op(16'h0005, 16'h0005, 1'b0, 1, e);

    e.sum  = 16'h0100;
    e.cout = 1'b0;
    e.err  = ERR_ON;
    run_op(16'h00A0, 16'h0000, 1'b0, 1, e);
    e = model(16'h0042, 16'h0017, 1'b0);
    run_op(16'h0042, 16'h0017, 1'b0, 0, e);

    for (int i = 0; i < 40; i++) begin
      av = rnd_bcd();
      bv = rnd_bcd();
      c  = 1'($urandom_range(0, 1));
      e  = model(av, bv, c);
      run_op(av, bv, c, $urandom_range(0, 3), e);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("queue drained", 64'(expq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
